lru_ctrl: RTL
=============

# lru_ctrl

Sequencer and arbiter for the 8192-entry, 3-bit tree-PLRU register file used by the 4-way L1.
- Owns the file's single read/modify/write port and shares it between three requesters: victim lookups from the miss path, fill updates from the refill path, and hit updates from tag compare.
- Runs a post-reset initialisation sweep.
- Decodes PLRU bits into a one-hot victim way.
- Sits between the cache pipeline and the LRU regfile.

## Interface
Parameters
- ENTRIES, 8192: LRU sets; index width is 13.

Ports
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- vreq_valid  in  1  victim lookup request.
- vreq_idx  in  13  set index for the lookup.
- vreq_ready  out  1  lookup accepted this cycle.
- vrsp_valid  out  1  victim response valid; one-cycle pulse.
- vrsp_way  out  4  one-hot victim way.
- fill_valid  in  1  fill update request.
- fill_idx  in  13  set index.
- fill_way  in  4  one-hot way being filled.
- fill_ready  out  1  fill update accepted.
- hit_valid  in  1  hit update request.
- hit_idx  in  13  set index.
- hit_way  in  4  one-hot hit way.
- hit_ready  out  1  hit update accepted.
- busy  out  1  init sweep in progress.
- lru_ra  out  13  regfile read address.
- lru_wa  out  13  regfile write address; always equal to lru_ra.
- lru_way_sel  out  4  regfile way select.
- lru_wr  out  1  regfile write enable.
- lru_rd  in  3  regfile read data (combinational from lru_ra).

## Operation
States are INIT_A, INIT_B and RUN.

Reset:
- State is INIT_A with sweep counter = 0.
- busy=1. All ready outputs=0, vrsp_valid=0, vrsp_way=0, lru_wr=0, lru_ra=0, lru_way_sel=0.
- Round-robin pointer favours fill.

Init sweep:
- The regfile can only write via its update rules. Zeroing an entry therefore takes two writes:
  - INIT_A: write way_sel=4'b0100, giving {1,0,b0}.
  - INIT_B: write way_sel=4'b0001, giving 3'b000.
- Address = counter. INIT_A→INIT_B each cycle; INIT_B→INIT_A with counter+1.
- At counter=ENTRIES-1 in INIT_B, go to RUN and drop busy the next cycle.
- Total sweep is 16384 cycles. No ready is asserted during the sweep.

RUN arbitration, one grant per cycle:
- A victim request has absolute priority.
- Between fill and hit, round-robin.
  - The pointer flips to the other requester only after a fill or hit grant made while both were valid.
  - A lone requester is granted whenever the victim port is idle.
- ready = grant, combinational from the valid inputs and state. The transfer happens on valid&ready.

Victim grant:
- lru_ra=vreq_idx, lru_wr=0.
- lru_rd is registered and decoded to vrsp_way the next cycle:
  - b2=0: b1=0 → 4'b1000, b1=1 → 4'b0100.
  - b2=1: b0=0 → 4'b0010, b0=1 → 4'b0001.
- A lookup does not update the LRU state; the fill that follows does.

Update grant (fill or hit):
- lru_ra=lru_wa=idx, lru_way_sel=way, lru_wr=1. The regfile performs the read-modify-write in the same cycle.
- A way input that is not one-hot is a protocol error. The block passes it through unchanged.

Same-index back-to-back:
- A lookup in the cycle after an update to the same index sees the updated bits, because the regfile write is visible on the next cycle.
- No forwarding is required.

Reset asserted mid-sweep or mid-RUN:
- Returns immediately to INIT_A, counter=0, and restarts the full sweep.
- A pending vrsp_valid is dropped.

## Timing
- Victim: request accepted in cycle N → vrsp_valid/vrsp_way in cycle N+1. Throughput is 1 per cycle.
- Update: accepted in cycle N → regfile written at the edge ending cycle N.
- The ready outputs have no registered stage. Requesters may hold valid high across cycles; data must stay stable until ready.
- The lru_* outputs are combinational from the arbiter. When no grant is made, lru_wr=0 and lru_ra=0.
- busy falls in the cycle after the final INIT_B write; requests may be granted in that same cycle.

## Configuration
- LRU_CTRL_INIT_EN defined:
  - The init sweep runs as described.
  - busy is high for 16384 cycles after reset release.
- LRU_CTRL_INIT_EN not defined:
  - Reset goes directly to RUN. busy is tied 0 and the sweep counter is removed.
  - Initial LRU contents are the responsibility of the simulation or preload.

## Test plan
- Reset, then release with LRU_CTRL_INIT_EN → busy=1 for 16384 cycles; lru_ra cycles 0..8191 with way_sel alternating 0100/0001; all ready=0 throughout; then a lookup of idx 0x1FFF returns vrsp_way=4'b1000.
- After init: hit idx 5 way 4'b0001, then lookup idx 5 → bits 000→000 (b1 retained from init), vrsp_way=4'b1000. Then hit way 4'b1000 → bits 110, lookup → 4'b0010.
- Fill and hit both valid for 6 cycles with different indices → grants alternate fill, hit, fill, hit, fill, hit; each lru_wr=1 with matching idx and way.
- Victim, fill and hit all valid in the same cycle → only vreq_ready=1; fill/hit stall; the round-robin pointer does not advance.
- Update idx 7 way 4'b0100 in cycle N, lookup idx 7 in cycle N+1 → vrsp_way in cycle N+2 reflects b2=1,b1=0, i.e. 4'b0010 or 4'b0001 depending on b0.
- Assert reset in RUN with a lookup outstanding → vrsp_valid=0 next cycle; busy=1; sweep restarts at address 0.

Source files
------------

// File: rtl/lru_ctrl.sv
// lru_ctrl
// Sequencer and arbiter for the tree-PLRU register file of the 4-way L1.
// Owns the regfile's single read/modify/write port and shares it between
// victim lookups (miss path), fill updates (refill path) and hit updates
// (tag compare). Decodes the three PLRU bits into a one-hot victim way.
//
// Build option: define LRU_CTRL_INIT_EN to enable the post-reset sweep that
// zeroes every regfile entry. Without it, reset goes straight to RUN and
// busy is tied low.
//
// Ports
//   clk, reset                     clock, asynchronous active-low reset
//   vreq_valid/idx, vreq_ready     victim lookup request / accept
//   vrsp_valid, vrsp_way           victim response (one cycle after accept)
//   fill_valid/idx/way, fill_ready fill update request / accept
//   hit_valid/idx/way, hit_ready   hit update request / accept
//   busy                           init sweep in progress
//   lru_ra, lru_wa                 regfile read / write address (always equal)
//   lru_way_sel, lru_wr            regfile way select / write enable
//   lru_rd                         regfile read data, combinational from lru_ra
module lru_ctrl #(
  parameter int ENTRIES = 8192,
  localparam int IW = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vreq_valid,
  input  logic [IW-1:0] vreq_idx,
  output logic          vreq_ready,
  output logic          vrsp_valid,
  output logic [3:0]    vrsp_way,
  input  logic          fill_valid,
  input  logic [IW-1:0] fill_idx,
  input  logic [3:0]    fill_way,
  output logic          fill_ready,
  input  logic          hit_valid,
  input  logic [IW-1:0] hit_idx,
  input  logic [3:0]    hit_way,
  output logic          hit_ready,
  output logic          busy,
  output logic [IW-1:0] lru_ra,
  output logic [IW-1:0] lru_wa,
  output logic [3:0]    lru_way_sel,
  output logic          lru_wr,
  input  logic [2:0]    lru_rd
);

  typedef enum logic [1:0] {INIT_A, INIT_B, RUN} state_t;

  state_t state_q, state_d;
  logic   rr_fill_q;
  logic   run, grant_v, grant_f, grant_h;

`ifdef LRU_CTRL_INIT_EN
  localparam state_t RESET_STATE = INIT_A;
  logic [IW-1:0] cnt_q, cnt_d;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  // b2 selects the half, then b1 (upper half) or b0 (lower half) the way.
  function automatic logic [3:0] decode_victim(input logic [2:0] b);
    if (!b[2]) return b[1] ? 4'b0100 : 4'b1000;
    else       return b[0] ? 4'b0001 : 4'b0010;
  endfunction

  // Sweep sequencing: the regfile only writes through its update rules, so
  // each entry takes two writes (way 2 then way 0) to reach 3'b000.
  always_comb begin
    state_d = state_q;
`ifdef LRU_CTRL_INIT_EN
    cnt_d = cnt_q;
    case (state_q)
      INIT_A: state_d = INIT_B;
      INIT_B: begin
        if (cnt_q == IW'(ENTRIES - 1)) begin
          state_d = RUN;
        end else begin
          state_d = INIT_A;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
`endif
  end

  // Arbitration. Reset gates every grant so nothing is accepted or written
  // while reset is held. Victim wins outright; fill and hit share by a
  // round-robin pointer that only matters when both are valid.
  assign run        = reset && (state_q == RUN);
  assign grant_v    = run && vreq_valid;
  assign grant_f    = run && !vreq_valid && fill_valid && (!hit_valid || rr_fill_q);
  assign grant_h    = run && !vreq_valid && hit_valid && (!fill_valid || !rr_fill_q);
  assign vreq_ready = grant_v;
  assign fill_ready = grant_f;
  assign hit_ready  = grant_h;

  // Regfile port mux. Idle cycles park the address at 0 with no write.
  always_comb begin
    lru_ra      = '0;
    lru_way_sel = '0;
    lru_wr      = 1'b0;
    if (grant_v) begin
      lru_ra = vreq_idx;
    end else if (grant_f) begin
      lru_ra      = fill_idx;
      lru_way_sel = fill_way;
      lru_wr      = 1'b1;
    end else if (grant_h) begin
      lru_ra      = hit_idx;
      lru_way_sel = hit_way;
      lru_wr      = 1'b1;
`ifdef LRU_CTRL_INIT_EN
    end else if (reset && state_q == INIT_A) begin
      lru_ra      = cnt_q;
      lru_way_sel = 4'b0100;
      lru_wr      = 1'b1;
    end else if (reset && state_q == INIT_B) begin
      lru_ra      = cnt_q;
      lru_way_sel = 4'b0001;
      lru_wr      = 1'b1;
`endif
    end
  end

  assign lru_wa = lru_ra;

`ifdef LRU_CTRL_INIT_EN
  assign busy = (state_q != RUN);
`else
  assign busy = 1'b0;
`endif

  // State, round-robin pointer and the registered victim response. The
  // pointer moves only after a contested fill/hit grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RESET_STATE;
      rr_fill_q  <= 1'b1;
      vrsp_valid <= 1'b0;
      vrsp_way   <= 4'b0000;
`ifdef LRU_CTRL_INIT_EN
      cnt_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (grant_f && hit_valid) begin
        rr_fill_q <= 1'b0;
      end else if (grant_h && fill_valid) begin
        rr_fill_q <= 1'b1;
      end
      vrsp_valid <= grant_v;
      vrsp_way   <= grant_v ? decode_victim(lru_rd) : 4'b0000;
`ifdef LRU_CTRL_INIT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule
